// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encoding,
// opcode/funct constants and the datapath select/ALU control codes.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB,
    ADDIEX, SLTIEX, LUIEX, IMMWB, BEQ, BLEZ, JUMP, TRAP
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;

  // ALU control
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;

  // ALU B operand select
  localparam logic [2:0] SRCB_REGB  = 3'd0;
  localparam logic [2:0] SRCB_FOUR  = 3'd1;
  localparam logic [2:0] SRCB_IMM   = 3'd2;
  localparam logic [2:0] SRCB_IMMSH = 3'd3;
  localparam logic [2:0] SRCB_UPPER = 3'd4;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_aludec.sv
// R-type ALU decoder.
//   funct       : instr[5:0]
//   alucontrol  : ALU operation for the supported R-type functs
//   funct_valid : 1 when funct is one of ADD/SUB/AND/OR/SLT/SLL
module mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       funct_valid
);

  always_comb begin
    alucontrol  = ALU_AND;
    funct_valid = 1'b1;
    case (funct)
      F_ADD:   alucontrol = ALU_ADD;
      F_SUB:   alucontrol = ALU_SUB;
      F_AND:   alucontrol = ALU_AND;
      F_OR:    alucontrol = ALU_OR;
      F_SLT:   alucontrol = ALU_SLT;
      F_SLL:   alucontrol = ALU_SLL;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS sequencing controller (Moore FSM).
//   clk, reset (async, active-low)
//   op, funct           : fields from the instruction register
//   zero, ltez          : ALU flags used by BEQ / BLEZ
//   mem_ready           : shared memory completes the access this cycle
//   mem_req/iord/memwrite/irwrite/pcen/pcsrc : memory and PC control
//   alusrca/alusrcb/alucontrol               : ALU operand and op select
//   regdst/memtoreg/regwrite                 : register writeback control
//   illegal             : controller parked in TRAP
//   instret             : retired-instruction counter (wraps)
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             ltez,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [2:0]       alusrcb,
  output logic [3:0]       alucontrol,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state, next;
  logic [3:0] rt_alucontrol;
  logic       funct_valid;
  logic       mem_req_c, memwrite_c, irwrite_c, pcen_c, regwrite_c;

  mc_aludec u_aludec (
    .funct       (funct),
    .alucontrol  (rt_alucontrol),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next;
  end

  // An instruction retires on every transition back into FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              instret <= '0;
    else if (state != FETCH && next == FETCH) instret <= instret + CNT_W'(1);
  end

  always_comb begin
    next       = state;
    mem_req_c  = 1'b0;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcen_c     = 1'b0;
    pcsrc      = PC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REGB;
    alucontrol = ALU_AND;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        mem_req_c  = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          next      = DECODE;
        end
      end
      DECODE: begin
        // Branch target PC+4+(imm<<2) is computed here and lands in ALUOut.
        alusrcb    = SRCB_IMMSH;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = funct_valid ? RTEXE : TRAP;
          OP_BEQ:       next = BEQ;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          OP_SLTI:      next = SLTIEX;
          OP_LUI:       next = LUIEX;
          OP_BLEZ:      next = BLEZ;
          default:      next = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        next       = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        next       = FETCH;
      end
      MEMWR: begin
        // memwrite stays high across wait cycles; commit happens on mem_ready.
        mem_req_c  = 1'b1;
        iord       = 1'b1;
        memwrite_c = 1'b1;
        if (mem_ready) next = FETCH;
      end
      RTEXE: begin
        alusrca    = 1'b1;
        alucontrol = rt_alucontrol;
        next       = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        next       = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        next       = IMMWB;
      end
      SLTIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_SLT;
        next       = IMMWB;
      end
      LUIEX: begin
        // rs is $0 for LUI, so A + upperimm yields the upper immediate.
        alusrca    = 1'b1;
        alusrcb    = SRCB_UPPER;
        alucontrol = ALU_ADD;
        next       = IMMWB;
      end
      IMMWB: begin
        regwrite_c = 1'b1;
        next       = FETCH;
      end
      BEQ: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        pcen_c     = zero;
        next       = FETCH;
      end
      BLEZ: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        pcen_c     = ltez;
        next       = FETCH;
      end
      JUMP: begin
        pcsrc  = PC_JUMP;
        pcen_c = 1'b1;
        next   = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  // Reset is asynchronous, so strobes must be masked combinationally while it is held.
  assign mem_req  = mem_req_c  & reset;
  assign memwrite = memwrite_c & reset;
  assign irwrite  = irwrite_c  & reset;
  assign pcen     = pcen_c     & reset;
  assign regwrite = regwrite_c & reset;

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multicycle sequencing controller for the MIPS datapath. It fetches instructions over a shared instruction/data memory port with a ready handshake and steps each instruction through Fetch, Decode, Execute, Memory and Writeback states. It drives all datapath mux selects, write strobes and ALU control, and keeps a retired-instruction counter. Instruction set: R-type (ADD, SUB, AND, OR, SLT, SLL), LW, SW, BEQ, ADDI, J, SLTI, LUI, BLEZ.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
op  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU result == 0
ltez  in  1  ALU zero | sign of sum
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
iord  out  1  memory address select: 0 = PC, 1 = ALUOut register
memwrite  out  1  memory write
irwrite  out  1  load the instruction register
pcen  out  1  PC load enable
pcsrc  out  2  PC source: 0 = ALU result, 1 = ALUOut register, 2 = jump target
alusrca  out  1  ALU A: 0 = PC, 1 = register A
alusrcb  out  3  ALU B: 0 = register B, 1 = const 4, 2 = signimm, 3 = signimm<<2, 4 = upperimm
alucontrol  out  4  0010 add, 1010 sub, 0000 and, 0001 or, 1011 slt, 0100 sll
regdst  out  1  register write address: 0 = rt, 1 = rd
memtoreg  out  1  writeback source: 0 = ALUOut, 1 = memory data
regwrite  out  1  register file write
illegal  out  1  controller is in TRAP
instret  out  CNT_W  count of retired instructions

Behaviour:
- Moore FSM, 4-bit state register. Outputs are a combinational decode of the state, gated by mem_ready, zero and ltez where noted. Any output not listed for a state is 0.
- Reset (reset = 0): state goes to FETCH and instret to 0 immediately. While reset is held, mem_req, memwrite, irwrite, pcen and regwrite are forced to 0. Reset during any state, including a pending memory wait, abandons the instruction.
- FETCH:
  - mem_req = 1, iord = 0, alusrca = 0, alusrcb = 1, add, pcsrc = 0.
  - mem_ready = 0: hold state; irwrite and pcen stay 0.
  - mem_ready = 1: irwrite = 1, pcen = 1, next state DECODE.
- DECODE: alusrca = 0, alusrcb = 3, add (branch target is captured into ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTEXE if funct is a supported R-type, else TRAP
  - 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP; 001010 -> SLTIEX; 001111 -> LUIEX; 000110 -> BLEZ
  - any other op -> TRAP
- MEMADR: alusrca = 1, alusrcb = 2, add. Next: MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req = 1, iord = 1. Hold until mem_ready = 1, then MEMWB.
- MEMWB: memtoreg = 1, regdst = 0, regwrite = 1. Next FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = 1, held through the whole wait. The write commits in the mem_ready = 1 cycle. Next FETCH.
- RTEXE: alusrca = 1, alusrcb = 0, alucontrol from the funct decode. Next ALUWB.
- ALUWB: regdst = 1, regwrite = 1. Next FETCH.
- ADDIEX / SLTIEX / LUIEX:
  - all use alusrca = 1
  - ADDIEX: alusrcb = 2, add
  - SLTIEX: alusrcb = 2, slt
  - LUIEX: alusrcb = 4, add (rs = $0)
  - next IMMWB
- IMMWB: regdst = 0, regwrite = 1. Next FETCH.
- BEQ: alusrca = 1, alusrcb = 0, sub, pcsrc = 1, pcen = zero. Next FETCH.
- BLEZ: alusrca = 1, alusrcb = 0 (rt = $0), sub, pcsrc = 1, pcen = ltez. Next FETCH.
- JUMP: pcsrc = 2, pcen = 1. Next FETCH.
- TRAP: illegal = 1, all strobes 0. Stays in TRAP until reset.
- instret increments by 1 in every cycle whose next state is FETCH and current state is not FETCH. Non-taken branches count as retired. TRAP never increments. The counter wraps modulo 2^CNT_W.
- Instruction latency with zero wait states:
  - LW: 5 cycles
  - SW, R-type, ADDI, SLTI, LUI: 4 cycles
  - BEQ, BLEZ, J: 3 cycles
  - each memory wait cycle adds 1.

Decomposition:
- Package mips_mc_pkg:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, ADDIEX, SLTIEX, LUIEX, IMMWB, BEQ, BLEZ, JUMP, TRAP
  - opcode constants and funct constants
  - alucontrol codes, alusrcb codes, pcsrc codes
- One sub-module, mc_aludec: funct -> alucontrol plus a funct_valid flag.

Test Plan:
- Reset held low, mem_ready = 1 -> state FETCH, instret = 0, all strobes 0. Release reset -> irwrite = 1 and pcen = 1 in the first cycle.
- LW (op = 100011), mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> regwrite = 1, memtoreg = 1 on cycle 10; instret = 1.
- R-type ADD (funct = 100000) -> alucontrol = 0010 in RTEXE. SLL (funct = 000000) -> alucontrol = 0100. ALUWB has regdst = 1 and regwrite = 1; 4 cycles each.
- BEQ with zero = 1 -> pcen = 1, pcsrc = 1 in cycle 3. With zero = 0 -> pcen = 0. BLEZ with ltez = 1 -> pcen = 1. All three increment instret.
- op = 111111, or R-type funct = 000111 -> TRAP after DECODE, illegal = 1 and held, instret frozen. Pulsing reset low returns to FETCH.
- SW with reset asserted mid-MEMWR while mem_ready = 0 -> memwrite drops to 0 immediately, state FETCH, instret = 0.
